// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Data-memory side of the 8-bit CPU. A 2**ADDR_WIDTH-word memory with a
//   fixed LATENCY-edge access time, presented to the CPU through a BUSYWAIT
//   stall handshake. One access is in flight at a time.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset; clears FSM, READDATA and memory
//   READ       load request
//   WRITE      store request (wins over READ when both are high)
//   ADDRESS    word address (ALU RESULT)
//   WRITEDATA  store data (register file OUT1)
//   READDATA   registered load result, updates only on a read completion
//   BUSYWAIT   stall to the CPU; high from the request cycle to completion
//
// LATENCY counts edges from the accepting edge to the completion edge
// inclusive; legal range 2..15 (counter is 4 bits).
module data_memory_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  BUSYWAIT
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  state_t state, state_nxt;
  logic [3:0] cnt;
  req_t       req;
  logic       accept, complete;

  // Packed storage so the whole array clears in one reset assignment.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // BUSYWAIT is combinational on the request in IDLE so the CPU stalls in
  // the very cycle it raises READ/WRITE. DONE drops it for one cycle and
  // ignores requests, giving the CPU a cycle to advance and deassert.
  always_comb begin
    state_nxt = state;
    BUSYWAIT  = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = READ | WRITE;
        if (READ | WRITE) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        BUSYWAIT = 1'b1;
        if (cnt == 4'd1) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is captured on the accept edge; inputs are don't-care after.
  // The accept edge itself is the first of LATENCY edges, so the countdown
  // starts at LATENCY-1 and completion fires when it reads 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
      req <= '0;
    end else if (accept) begin
      req <= '{wr: WRITE, addr: ADDRESS, data: WRITEDATA};
      cnt <= 4'(LATENCY - 1);
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Reset mid-access simply wins: the pending write is dropped along with
  // the rest of the memory contents.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem      <= '0;
      READDATA <= '0;
    end else if (complete) begin
      if (req.wr) mem[req.addr] <= req.data;
      else        READDATA      <= mem[req.addr];
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder. A transaction-level model (byte array,
// edges-remaining counter) predicts BUSYWAIT/READDATA every cycle; directed
// tests add literal checks for latency, data and reset behaviour. A second
// instance built with LATENCY=2 covers the short-latency repeat pattern.
module tb_data_memory_responder;
  localparam int LAT = 5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       READ = 1'b0, WRITE = 1'b0;
  logic [7:0] ADDRESS = 8'h00, WRITEDATA = 8'h00;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  logic       r2 = 1'b0, w2 = 1'b0;
  logic [7:0] a2 = 8'h00, d2 = 8'h00;
  logic [7:0] rd2;
  logic       bw2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  data_memory_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
  );

  data_memory_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LATENCY(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .READ(r2), .WRITE(w2), .ADDRESS(a2),
    .WRITEDATA(d2), .READDATA(rd2), .BUSYWAIT(bw2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // mph: 0 = free, >0 = edges left until completion, -1 = cool-down cycle
  logic [7:0] mmem [256];
  logic [7:0] mrd = 8'h00;
  int         mph = 0;
  logic       mop = 1'b0;
  logic [7:0] ma = 8'h00, md = 8'h00;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
      mrd = 8'h00;
      mph = 0;
    end else if (mph == 0) begin
      if (READ | WRITE) begin
        ma = ADDRESS; md = WRITEDATA; mop = WRITE; mph = LAT - 1;
      end
    end else if (mph < 0) begin
      mph = 0;
    end else begin
      mph = mph - 1;
      if (mph == 0) begin
        if (mop) mmem[ma] = md;
        else     mrd = mmem[ma];
        mph = -1;
      end
    end
  end

  function automatic logic exp_bw();
    if (RESET)    return 1'b0;
    if (mph > 0)  return 1'b1;
    if (mph == 0) return READ | WRITE;
    return 1'b0;
  endfunction

  always @(negedge CLK) begin
    chk("bw", {31'd0, BUSYWAIT}, {31'd0, exp_bw()});
    chk("rdata", {24'd0, READDATA}, {24'd0, mrd});
  end

  // ---------------- directed ----------------
  // Raise a request in IDLE, drop it (and apply late addr/data) after the
  // accept edge, count BUSYWAIT-high cycles, return READDATA seen in DONE.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] a_late, input logic [7:0] d_late,
                        output int nb, output logic [7:0] rdat);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d; nb = 0;
    @(negedge CLK); if (BUSYWAIT === 1'b1) nb++;
    @(posedge CLK); #2;
    READ = 1'b0; WRITE = 1'b0; ADDRESS = a_late; WRITEDATA = d_late;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (BUSYWAIT !== 1'b1) break;
      nb++;
    end
    rdat = READDATA;
    @(posedge CLK); #2;
  endtask

  task automatic do_rd(input logic [7:0] a, input string nm, input logic [7:0] exp);
    int nb; logic [7:0] r;
    access(1'b1, 1'b0, a, 8'h00, a, 8'h00, nb, r);
    chk({nm, "_lat"}, nb, LAT);
    chk(nm, {24'd0, r}, {24'd0, exp});
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] al,
                       input logic [7:0] dl, input string nm);
    int nb; logic [7:0] r;
    access(1'b0, 1'b1, a, d, al, dl, nb, r);
    chk({nm, "_lat"}, nb, LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb; logic [7:0] r;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_bw", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_rdata", {24'd0, READDATA}, 32'd0);
    RESET = 1'b0;

    // reset contents read back as zero
    do_rd(8'h10, "rd_default", 8'h00);

    // write then read, neighbour untouched
    do_wr(8'h10, 8'h5A, 8'h10, 8'h5A, "wr10");
    do_rd(8'h10, "rd10", 8'h5A);
    do_rd(8'h11, "rd11", 8'h00);

    // inputs changed after the accept edge must not affect the access
    do_wr(8'h20, 8'hC3, 8'h21, 8'hFF, "wr20chg");
    do_rd(8'h21, "rd21", 8'h00);
    do_rd(8'h20, "rd20", 8'hC3);

    // READ and WRITE together is a write; READDATA holds
    access(1'b1, 1'b1, 8'hFF, 8'h7E, 8'hFF, 8'h7E, nb, r);
    chk("both_lat", nb, LAT);
    chk("both_rdata_hold", {24'd0, r}, 32'h0000_00C3);
    do_rd(8'hFF, "rdFF", 8'h7E);

    // held read: 5 high, 1 low, 5 high, 1 low
    READ = 1'b1; ADDRESS = 8'h10;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk("held_bw", {31'd0, BUSYWAIT}, {31'd0, (k % 6) != 5});
      if (k == 5) chk("held_rd", {24'd0, READDATA}, 32'h0000_005A);
    end
    @(posedge CLK); #2;
    READ = 1'b0;
    @(posedge CLK); #2;

    // reset in the middle of a write
    WRITE = 1'b1; ADDRESS = 8'h30; WRITEDATA = 8'hAA;
    @(posedge CLK); #2;
    WRITE = 1'b0;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk("mid_bw", {31'd0, BUSYWAIT}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("rst_async_bw", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_async_rdata", {24'd0, READDATA}, 32'd0);
    @(posedge CLK); #2;
    RESET = 1'b0;
    do_rd(8'h30, "rd30_after_rst", 8'h00);
    do_rd(8'h10, "rd10_cleared", 8'h00);

    // LATENCY=2 instance: write, then held read -> 2 high, 1 low repeating
    a2 = 8'h10; d2 = 8'h5A; w2 = 1'b1;
    @(posedge CLK); #2;
    w2 = 1'b0;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    r2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("l2_bw", {31'd0, bw2}, {31'd0, (k % 3) != 2});
      if (k == 2) chk("l2_rd", {24'd0, rd2}, 32'h0000_005A);
    end
    @(posedge CLK); #2;
    r2 = 1'b0;
    repeat (2) @(posedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
